fp16_accumulator: RTL and testbench

Downstream consumer of the FP16 multiplier. Sums a stream of half-precision products (sign/5-bit exp/10-bit frac, bias 15) into one FP16 dot-product result per vector, for the neuron datapath. It accepts one product per handshake and uses a multi-cycle align/add/normalise FSM. It presents the sum, element count and overflow flag on a valid/ready output.

---
 rtl/fp16_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_fp16_accumulator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fp16_accumulator.sv
// Sums a stream of FP16 products into one FP16 result per vector, using a multi-cycle align/add/normalise FSM.
// Latency: 4 cycles per element (ACCEPT, ALIGN, ADD, NORM); the result appears 4 cycles after the last element's accept edge.
// Backpressure: din_ready is high only in ACCEPT; the result is held in DONE until dout_ready.
module fp16_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic [15:0]      dout,
    output logic [CNT_W-1:0] dout_count,
    output logic             dout_ovf,
    output logic             dout_valid,
    input  logic             dout_ready
);

    typedef enum logic [2:0] {ACCEPT, ALIGN, ADD, NORM, DONE} state_t;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    state_t             state, state_nxt;
    fp16_t              acc, opb;
    logic               last_flag;
    logic [CNT_W-1:0]   count;
    logic               ovf;

    // Stage registers between the FSM steps
    logic               big_sign, small_sign;
    logic [4:0]         big_exp;
    logic [10:0]        big_man, small_man;
    logic [11:0]        sum;
    logic               sum_sign;
    logic [4:0]         sum_exp;

    // Align datapath: the accumulator is operand A, the captured product is operand B
    logic [10:0]        man_a, man_b;
    logic               a_big;
    logic [4:0]         exp_diff;
    logic               al_big_sign, al_small_sign;
    logic [4:0]         al_big_exp;
    logic [10:0]        al_big_man, al_small_man;

    always_comb begin
        man_a         = (acc.exp == 5'd0) ? 11'd0 : {1'b1, acc.frac};
        man_b         = (opb.exp == 5'd0) ? 11'd0 : {1'b1, opb.frac};
        a_big         = (acc.exp >= opb.exp);
        exp_diff      = a_big ? (acc.exp - opb.exp) : (opb.exp - acc.exp);
        al_big_sign   = a_big ? acc.sign : opb.sign;
        al_small_sign = a_big ? opb.sign : acc.sign;
        al_big_exp    = a_big ? acc.exp  : opb.exp;
        al_big_man    = a_big ? man_a    : man_b;
        al_small_man  = (exp_diff >= 5'd11) ? 11'd0 : ((a_big ? man_b : man_a) >> exp_diff);
    end

    // Add datapath: sign-magnitude add/subtract, exact zero is forced positive
    logic [11:0]        add_sum;
    logic               add_sign;

    always_comb begin
        if (big_sign == small_sign) begin
            add_sum  = {1'b0, big_man} + {1'b0, small_man};
            add_sign = big_sign;
        end else if (big_man >= small_man) begin
            add_sum  = {1'b0, big_man} - {1'b0, small_man};
            add_sign = big_sign;
        end else begin
            add_sum  = {1'b0, small_man} - {1'b0, big_man};
            add_sign = small_sign;
        end
        if (add_sum == 12'd0) add_sign = 1'b0;
    end

    // Normalise datapath: single-cycle leading-zero count, saturate or flush on range exit
    logic [3:0]         lzc;
    logic [10:0]        norm_man;
    logic signed [6:0]  norm_exp;
    fp16_t              norm_res;
    logic               norm_ovf;

    always_comb begin
        lzc = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (sum[i]) lzc = 4'(10 - i);
        end
        if (sum[11]) begin
            norm_man = sum[11:1];
            norm_exp = $signed({2'b00, sum_exp}) + 7'sd1;
        end else begin
            norm_man = sum[10:0] << lzc;
            norm_exp = $signed({2'b00, sum_exp}) - $signed({3'b000, lzc});
        end
        norm_ovf = 1'b0;
        if (sum == 12'd0) begin
            norm_res = '0;
        end else if (norm_exp >= 7'sd31) begin
            norm_res = '{sign: sum_sign, exp: 5'h1E, frac: 10'h3FF};
            norm_ovf = 1'b1;
        end else if (norm_exp <= 7'sd0) begin
            norm_res = '0;
        end else begin
            norm_res = '{sign: sum_sign, exp: norm_exp[4:0], frac: norm_man[9:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCEPT;
            acc        <= '0;
            opb        <= '0;
            last_flag  <= 1'b0;
            count      <= '0;
            ovf        <= 1'b0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            big_exp    <= '0;
            big_man    <= '0;
            small_man  <= '0;
            sum        <= '0;
            sum_sign   <= 1'b0;
            sum_exp    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ACCEPT: if (din_valid) begin
                    opb       <= din;
                    last_flag <= din_last;
                    if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
                end
                ALIGN: begin
                    big_sign   <= al_big_sign;
                    small_sign <= al_small_sign;
                    big_exp    <= al_big_exp;
                    big_man    <= al_big_man;
                    small_man  <= al_small_man;
                end
                ADD: begin
                    sum      <= add_sum;
                    sum_sign <= add_sign;
                    sum_exp  <= big_exp;
                end
                NORM: begin
                    acc <= norm_res;
                    if (norm_ovf) ovf <= 1'b1;
                end
                DONE: if (dout_ready) begin
                    acc   <= '0;
                    count <= '0;
                    ovf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT:  if (din_valid) state_nxt = ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = last_flag ? DONE : ACCEPT;
            DONE:    if (dout_ready) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    always_comb begin
        din_ready  = (state == ACCEPT);
        dout_valid = (state == DONE);
        dout       = acc;
        dout_count = count;
        dout_ovf   = ovf;
    end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed bench for fp16_accumulator: vector table plus backpressure and mid-vector reset sequences.
module tb_fp16_accumulator;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      din;
    logic             din_valid;
    logic             din_last;
    logic             din_ready;
    logic [15:0]      dout;
    logic [CNT_W-1:0] dout_count;
    logic             dout_ovf;
    logic             dout_valid;
    logic             dout_ready;

    int total = 0;
    int bad   = 0;

    fp16_accumulator #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_count (dout_count),
        .dout_ovf   (dout_ovf),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] e_dout;
        int          e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n elements; return once the last element has been accepted (1ns after its edge)
    task automatic push(input int n, input logic [15:0] d0, input logic [15:0] d1, input string name);
        logic [15:0] d;
        int guard;
        for (int i = 0; i < n; i++) begin
            d         = (i == 0) ? d0 : d1;
            din       = d;
            din_last  = (i == n - 1);
            din_valid = 1'b1;
            guard     = 0;
            while (!din_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20) check({name, " din_ready timeout"}, 0, 1);
            tick();
            din_valid = 1'b0;
            din_last  = 1'b0;
        end
    endtask

    // Wait for the result and check value, count, ovf and latency from the last accept edge
    task automatic expect_result(input string name, input logic [15:0] e_dout,
                                 input int e_cnt, input logic e_ovf);
        int lat;
        lat = 1;
        while (!dout_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, " latency"}, lat, 4);
        check({name, " dout"}, int'(dout), int'(e_dout));
        check({name, " count"}, int'(dout_count), e_cnt);
        check({name, " ovf"}, int'(dout_ovf), int'(e_ovf));
    endtask

    task automatic ack();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"add_1_2",     2, 16'h3C00, 16'h4000, 16'h4200, 2, 1'b0};
        tbl[1] = '{"cancel",      2, 16'h3C00, 16'hBC00, 16'h0000, 2, 1'b0};
        tbl[2] = '{"sat_pos",     2, 16'h7BFF, 16'h7BFF, 16'h7BFF, 2, 1'b1};
        tbl[3] = '{"sat_neg",     2, 16'hFBFF, 16'hFBFF, 16'hFBFF, 2, 1'b1};
        tbl[4] = '{"align_10",    2, 16'h3C00, 16'h1400, 16'h3C01, 2, 1'b0};
        tbl[5] = '{"align_out",   2, 16'h3C00, 16'h0400, 16'h3C00, 2, 1'b0};
        tbl[6] = '{"denorm",      1, 16'h0001, 16'h0000, 16'h0000, 1, 1'b0};

        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset din_ready", int'(din_ready), 1);
        check("reset dout_valid", int'(dout_valid), 0);
        check("reset dout", int'(dout), 0);
        check("reset count", int'(dout_count), 0);
        check("reset ovf", int'(dout_ovf), 0);

        for (int v = 0; v < 7; v++) begin
            push(tbl[v].n, tbl[v].d0, tbl[v].d1, tbl[v].name);
            expect_result(tbl[v].name, tbl[v].e_dout, tbl[v].e_cnt, tbl[v].e_ovf);
            ack();
            check({tbl[v].name, " valid drop"}, int'(dout_valid), 0);
        end

        // Result held under backpressure
        push(2, 16'h3C00, 16'h4000, "bp");
        expect_result("bp", 16'h4200, 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp hold valid", int'(dout_valid), 1);
            check("bp hold dout", int'(dout), 16'h4200);
            check("bp hold count", int'(dout_count), 2);
            check("bp hold din_ready", int'(din_ready), 0);
        end
        ack();
        push(1, 16'h3800, 16'h0000, "after_bp");
        expect_result("after_bp", 16'h3800, 1, 1'b0);
        ack();

        // Reset during ALIGN discards the partial vector
        din       = 16'h4000;
        din_last  = 1'b0;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("mid pre-reset din_ready", int'(din_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset din_ready", int'(din_ready), 1);
        check("mid reset dout_valid", int'(dout_valid), 0);
        push(2, 16'h3E00, 16'h3E00, "after_rst");
        expect_result("after_rst", 16'h4200, 2, 1'b0);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
